// File: rtl/sub_fmt_pkg.sv
// Shared types and the raw-difference to sign-magnitude/BCD conversion
// used by the subtractor result formatter.
package sub_fmt_pkg;

    localparam int DATA_W = 4;
    localparam int BCD_W  = 4;

    typedef struct packed {
        logic              neg;
        logic [DATA_W-1:0] mag;
        logic [BCD_W-1:0]  tens;
        logic [BCD_W-1:0]  ones;
    } fmt_entry_t;

    // A clear carry means a < b, so the magnitude is the two's complement of diff.
    function automatic fmt_entry_t to_fmt(input logic [DATA_W-1:0] diff, input logic carry);
        fmt_entry_t e;
        e.neg  = !carry;
        e.mag  = carry ? diff : (~diff + DATA_W'(1));
        e.tens = (e.mag >= DATA_W'(10)) ? BCD_W'(1) : BCD_W'(0);
        e.ones = e.tens[0] ? (e.mag - DATA_W'(10)) : e.mag;
        return e;
    endfunction

endpackage

// File: rtl/sub_fmt_fifo.sv
// Circular FIFO of formatted entries; pointers carry one extra wrap bit
// so full and empty can be told apart.
module sub_fmt_fifo
    import sub_fmt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  fmt_entry_t wdata,
    output fmt_entry_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fmt_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage has no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sub_result_formatter.sv
// Formats raw subtractor results into sign-magnitude plus BCD, queues them
// for a consumer, and keeps total/negative result statistics.
module sub_result_formatter
    import sub_fmt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_diff,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_neg,
    output logic [DATA_W-1:0] out_mag,
    output logic [BCD_W-1:0]  out_tens,
    output logic [BCD_W-1:0]  out_ones,
    output logic [CNT_W-1:0]  total_count,
    output logic [CNT_W-1:0]  neg_count
);

    fmt_entry_t wr_entry;
    fmt_entry_t rd_entry;
    logic       full;
    logic       empty;
    logic       accept;
    logic       take;

    assign wr_entry  = to_fmt(in_diff, in_carry);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    sub_fmt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (take),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty)
    );

    assign out_neg  = rd_entry.neg;
    assign out_mag  = rd_entry.mag;
    assign out_tens = rd_entry.tens;
    assign out_ones = rd_entry.ones;

    // A clear coinciding with an accept restarts the counts from that word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_count <= '0;
            neg_count   <= '0;
        end else if (accept) begin
            if (clear) begin
                total_count <= CNT_W'(1);
                neg_count   <= CNT_W'(wr_entry.neg);
            end else begin
                total_count <= total_count + CNT_W'(1);
                if (wr_entry.neg && (neg_count != '1))
                    neg_count <= neg_count + CNT_W'(1);
            end
        end else if (clear) begin
            total_count <= '0;
            neg_count   <= '0;
        end
    end

endmodule

// File: tb/tb_sub_result_formatter.sv
// Directed-vector bench for sub_result_formatter with hand-computed expectations.
module tb_sub_result_formatter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_diff;
    logic       in_carry;
    logic       out_valid;
    logic       out_ready;
    logic       out_neg;
    logic [3:0] out_mag;
    logic [3:0] out_tens;
    logic [3:0] out_ones;
    logic [7:0] total_count;
    logic [7:0] neg_count;

    int vectors     = 0;
    int miscompares = 0;

    sub_result_formatter #(.DEPTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_diff     (in_diff),
        .in_carry    (in_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_neg     (out_neg),
        .out_mag     (out_mag),
        .out_tens    (out_tens),
        .out_ones    (out_ones),
        .total_count (total_count),
        .neg_count   (neg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input int v, input int n, input int m,
                              input int t, input int o);
        check({tag, ".valid"}, int'(out_valid), v);
        check({tag, ".neg"},   int'(out_neg),   n);
        check({tag, ".mag"},   int'(out_mag),   m);
        check({tag, ".tens"},  int'(out_tens),  t);
        check({tag, ".ones"},  int'(out_ones),  o);
    endtask

    task automatic check_counts(input string tag, input int tot, input int neg);
        check({tag, ".total"}, int'(total_count), tot);
        check({tag, ".negc"},  int'(neg_count),   neg);
    endtask

    // Advance one edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic c);
        in_valid = v;
        in_diff  = d;
        in_carry = c;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 1'b0);
        #3;
        check_head("reset", 0, 0, 0, 0, 0);
        check("reset.in_ready", int'(in_ready), 1);
        check_counts("reset", 0, 0);
        step();
        rst_n = 1'b1;
        step();

        // 6-5: positive 1, one cycle latency
        drive(1'b1, 4'b0001, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b0);
        check_head("p1", 1, 0, 1, 0, 1);
        check_counts("p1", 1, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("p1.drained", int'(out_valid), 0);

        // 15-15 then 3-7, back to back
        drive(1'b1, 4'b0000, 1'b1);
        step();
        drive(1'b1, 4'b1100, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b0);
        check_head("zero", 1, 0, 0, 0, 0);
        check_counts("pair", 3, 1);
        out_ready = 1'b1;
        step();
        check_head("neg4", 1, 1, 4, 0, 4);
        step();
        out_ready = 1'b0;

        // 0-15: magnitude 15 -> BCD 1,5
        drive(1'b1, 4'b0001, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b0);
        check_head("neg15", 1, 1, 15, 1, 5);
        check_counts("neg15", 4, 2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("neg15.drained", int'(out_valid), 0);

        // Fill to full with out_ready low; fifth word is held off
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'(k + 2), 1'b1);
            step();
        end
        check("full.in_ready", int'(in_ready), 0);
        drive(1'b1, 4'd6, 1'b1);
        step();
        check("full.hold", int'(in_ready), 0);
        check_counts("full", 8, 2);
        check_head("full.head", 1, 0, 2, 0, 2);
        out_ready = 1'b1;
        step();
        check("drain.in_ready", int'(in_ready), 1);
        check("drain.total_nopush", int'(total_count), 8);
        check_head("drain.h3", 1, 0, 3, 0, 3);
        step();
        drive(1'b0, 4'd0, 1'b0);
        check_counts("drain.fifth", 9, 2);
        check_head("drain.h4", 1, 0, 4, 0, 4);
        step();
        check_head("drain.h5", 1, 0, 5, 0, 5);
        step();
        check_head("drain.h6", 1, 0, 6, 0, 6);
        step();
        check("drain.empty", int'(out_valid), 0);

        // Clear alone, then saturate neg_count and wrap total_count
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_counts("clear", 0, 0);
        drive(1'b1, 4'b0001, 1'b0);
        for (int k = 0; k < 255; k++)
            step();
        check_counts("sat255", 255, 255);
        step();
        check_counts("wrap", 0, 255);
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive(1'b0, 4'd0, 1'b0);
        check_counts("clear_acc", 1, 1);
        step();
        check("sat.drained", int'(out_valid), 0);

        // Three queued entries then async reset between edges
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'(k + 7), 1'b1);
            step();
        end
        drive(1'b0, 4'd0, 1'b0);
        check_head("pre_rst", 1, 0, 7, 0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_head("mid_rst", 0, 0, 0, 0, 0);
        check("mid_rst.in_ready", int'(in_ready), 1);
        check_counts("mid_rst", 0, 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst.valid", int'(out_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sub_result_formatter.md
# sub_result_formatter

- Downstream stage of the 4-bit binary subtractor.
- Accepts each raw difference and carry (borrow-not) word under a valid/ready handshake and converts it to sign-magnitude plus two BCD digits.
- Buffers the converted words in a small FIFO for a display or logging consumer.
- Keeps running counts of total and negative results.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clear  in  1  synchronous clear of both counters; does not touch the FIFO.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block can accept; equals !full.
- in_diff  in  4  subtractor difference, a-b mod 16.
- in_carry  in  1  subtractor carry-out; 1 = a>=b (result non-negative), 0 = negative.
- out_valid  out  1  FIFO head valid; equals !empty.
- out_ready  in  1  consumer takes head.
- out_neg  out  1  sign of head entry.
- out_mag  out  4  magnitude of head entry, 0..15.
- out_tens  out  4  BCD tens digit of out_mag, 0 or 1.
- out_ones  out  4  BCD ones digit of out_mag, 0..9.
- total_count  out  CNT_W  accepted words; wraps modulo 2^CNT_W.
- neg_count  out  CNT_W  accepted negative words; saturates at all-ones.

## Operation
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Conversion is combinational at the FIFO write port. The stored entry is {neg, mag, tens, ones}.
  - neg = !in_carry.
  - mag = in_carry ? in_diff : (~in_diff + 1) mod 16.
  - tens = (mag >= 10).
  - ones = tens ? mag-10 : mag.
- Negative results never produce mag 0. A malformed input {carry=0, diff=0} is still converted, giving neg=1, mag=0; it is not flagged.
- FIFO: circular buffer with read and write pointers of log2(DEPTH)+1 bits. The MSB distinguishes full from empty; both pointers wrap naturally.
- Push and pop in the same cycle:
  - Allowed when not full and not empty; occupancy is unchanged.
  - When full, in_ready=0, so only the pop happens. There is no pass-through; in_ready rises the following cycle.
  - When empty, only the push happens. There is no bypass.
- Counters update on accept: total_count+1; neg_count+1 if neg and not saturated.
- clear and accept in the same cycle: counters load the accepted word's contribution. total_count=1; neg_count=1 if the word is negative, else 0.
- Handshake rules:
  - Upstream must hold in_diff, in_carry and in_valid stable while in_valid && !in_ready.
  - out_* holds stable while out_valid && !out_ready.

## Timing
- Latency: a word accepted at edge N appears on out_* with out_valid=1 after edge N, provided the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained while not full and out_ready=1.
- Reset values: in_ready=1; out_valid=0; out_neg=0; out_mag, out_tens, out_ones=0; total_count=0; neg_count=0.
- out_* data is read from the FIFO storage at the read pointer. When empty, out_* is forced to 0.
- Reset mid-operation: pointers and counters clear asynchronously, all entries are discarded, and no partial pop is seen.
- clear affects counters at the next edge only.

## Structure
- Package sub_fmt_pkg:
  - DATA_W=4 and BCD_W=4.
  - typedef struct packed fmt_entry_t {neg, mag[3:0], tens[3:0], ones[3:0]}.
  - function to_fmt(diff, carry) returning fmt_entry_t.
- Sub-module sub_fmt_fifo:
  - Parameterized on DEPTH; carries fmt_entry_t.
  - Ports: clk, rst_n, push, pop, wdata, rdata, full, empty.
- The top level holds the conversion, the handshake glue and the counters.

## Test plan
- diff=0001, carry=1 (6-5) -> out_neg=0, out_mag=1, out_tens=0, out_ones=1 one cycle after accept; total_count=1, neg_count=0.
- diff=0000, carry=1 (15-15), then diff=1100, carry=0 (3-7) -> first entry neg=0, mag=0, ones=0; second entry neg=1, mag=4; neg_count=1.
- diff=0001, carry=0 (0-15) -> neg=1, mag=15, tens=1, ones=5.
- out_ready=0, push 5 words with DEPTH=4 -> in_ready drops after the 4th accept and the 5th word stays presented. Then set out_ready=1 -> words drain in FIFO order, the 5th is accepted one cycle after the first pop, and total_count=5.
- neg_count forced near saturation with CNT_W=8 (255 negative accepts) -> neg_count holds at 255. total_count wraps 255->0 on accept 256. clear and a negative accept in the same cycle -> total_count=1, neg_count=1.
- Three entries queued, then rst_n pulsed low between edges -> out_valid, all out_* fields and both counters read 0 immediately; in_ready=1; no stale entry is delivered after reset releases.
